// File: rtl/delay_chain_ctrl.sv
// Control sequencer for a chain of DEPTH enable-gated delay registers (valid/last per stage).
// Latency: DEPTH cycles from accept to out_valid when there are no stalls; one beat per cycle.
// Backpressure: stages fill from the tail and bubbles collapse; in_ready drops only when stage 0 cannot shift.
module delay_chain_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [DEPTH-1:0] stage_ena,
    output logic [DEPTH-1:0] stage_vld,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] lst;
    logic [DEPTH-1:0] take;
    logic [DEPTH-1:0] ena;
    logic [DEPTH-1:0] src_lst;
    logic             accept_ok;
    logic             rdy;
    logic             accept;
    logic             emit;

    // Last flag each stage would load: the previous stage's flag, or in_last at the head.
    assign src_lst = (lst << 1) | DEPTH'(in_last);

    // Take/enable chain resolved from the output end back to the input so a stage
    // only shifts when the stage ahead is empty or is itself moving on.
    always_comb begin
        take            = '0;
        ena             = '0;
        take[DEPTH-1]   = vld[DEPTH-1] & out_ready;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            ena[i]      = vld[i-1] & (~vld[i] | take[i]);
            take[i-1]   = vld[i-1] & ena[i];
        end
        rdy             = rst & accept_ok & (~vld[0] | take[0]);
        ena[0]          = in_valid & rdy;
    end

    assign accept     = ena[0];
    assign emit       = vld[DEPTH-1] & out_ready;
    assign in_ready   = rdy;
    assign out_valid  = vld[DEPTH-1];
    assign out_last   = lst[DEPTH-1];
    assign stage_vld  = vld;
    assign stage_ena  = rst ? ena : '0;

    // Per-stage valid/last flags: load on enable, clear when the beat moves on, else hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= '0;
            lst <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ena[i]) begin
                    vld[i] <= 1'b1;
                    lst[i] <= src_lst[i];
                end else if (take[i]) begin
                    vld[i] <= 1'b0;
                end
            end
        end
    end

    // Occupancy tracks accepts minus emits; simultaneous events cancel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (accept && !emit) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (emit && !accept) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: a last beat closes intake until it has left the chain.
    always_comb begin
        state_nxt  = state;
        accept_ok  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                accept_ok = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    state_nxt = in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                accept_ok = 1'b1;
                if (accept && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (emit && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_delay_chain_ctrl.sv
// Bench for delay_chain_ctrl: random and directed stimulus against a beat-position model.
// Expected last flags are queued on accept and popped by an independent output monitor.
// Per-cycle model predicts in_ready, flags, enables, occupancy and frame status.
module tb_delay_chain_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 5;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_last;
    logic [DEPTH-1:0] stage_ena;
    logic [DEPTH-1:0] stage_vld;
    logic [CNT_W-1:0] occupancy;
    logic             busy;
    logic             frame_done;

    delay_chain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .stage_ena  (stage_ena),
        .stage_vld  (stage_vld),
        .occupancy  (occupancy),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;

    int      checks   = 0;
    int      failures = 0;
    mphase_t phase    = M_IDLE;
    int      pos_q[$];          // stage index of each beat in flight, oldest first
    bit      last_q[$];         // last flag of each beat in flight
    bit      sb_q[$];           // scoreboard: expected out_last per beat, in order
    bit      prev_rst_low = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic cycle(input bit iv, input bit il, input bit ordy, input bit r);
        int  n;
        bit  allowed;
        bit  e_rdy;
        bit  e_ov;
        bit  acc;
        bit  emit;
        int  e_vld;
        int  e_ena;
        int  bound;
        int  p;
        int  np[$];
        bit  nl[$];
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_last   = il;
        out_ready = ordy;
        #1;
        if (!r) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_stage_ena", stage_ena, 0);
            if (prev_rst_low) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_stage_vld", stage_vld, 0);
                chk("rst_occupancy", occupancy, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_done", frame_done, 0);
            end
            pos_q.delete();
            last_q.delete();
            sb_q.delete();
            phase        = M_IDLE;
            prev_rst_low = 1'b1;
            return;
        end
        prev_rst_low = 1'b0;

        n       = pos_q.size();
        allowed = (phase == M_IDLE) || (phase == M_RUN);
        e_rdy   = allowed && ((n < DEPTH) || ordy);
        e_ov    = (n > 0) && (pos_q[0] == DEPTH - 1);
        e_vld   = 0;
        foreach (pos_q[k]) e_vld |= (1 << pos_q[k]);
        acc     = iv && e_rdy;
        emit    = e_ov && ordy;

        // Each beat advances one stage unless it would land on the beat ahead.
        bound = DEPTH;
        e_ena = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0 && emit) continue;
            p = (pos_q[k] + 1 < bound - 1) ? pos_q[k] + 1 : bound - 1;
            if (p != pos_q[k]) e_ena |= (1 << p);
            np.push_back(p);
            nl.push_back(last_q[k]);
            bound = p;
        end
        if (acc) begin
            e_ena |= 1;
            np.push_back(0);
            nl.push_back(il);
        end

        chk("in_ready", in_ready, e_rdy);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) chk("out_last", out_last, last_q[0]);
        chk("stage_vld", stage_vld, e_vld);
        chk("stage_ena", stage_ena, e_ena);
        chk("occupancy", occupancy, n);
        chk("busy", busy, phase != M_IDLE);
        chk("frame_done", frame_done, phase == M_DONE);

        case (phase)
            M_IDLE:  if (acc) phase = il ? M_DRAIN : M_RUN;
            M_RUN:   if (acc && il) phase = M_DRAIN;
            M_DRAIN: if (emit && last_q[0]) phase = M_DONE;
            default: phase = M_IDLE;
        endcase
        pos_q  = np;
        last_q = nl;
        if (acc) sb_q.push_back(il);
    endtask

    // Empty the chain and leave intake open; a bounded wait.
    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (pos_q.size() == 0 && (phase == M_IDLE || phase == M_RUN)) break;
            cycle(0, 0, 1, 1);
        end
        if (!(pos_q.size() == 0 && (phase == M_IDLE || phase == M_RUN))) begin
            checks++;
            failures++;
            $display("FAIL drain_bound occupancy=%0d expected=0", occupancy);
        end
    endtask

    // Output monitor: every beat the DUT hands downstream is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid && out_ready) begin
                chk("sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) chk("sb_out_last", out_last, sb_q.pop_front());
            end
        end
    end

    initial begin
        int piv[6];
        int pord[6];
        piv  = '{90, 50, 100, 30, 70, 100};
        pord = '{90, 50, 30, 100, 20, 100};

        repeat (3) cycle(0, 0, 0, 0);

        // Streaming: ten back-to-back beats with a free downstream.
        for (int k = 0; k < 10; k++) cycle(1, 0, 1, 1);
        repeat (6) cycle(0, 0, 1, 1);

        // Back-pressure: fill, then hold out_ready low while still offering beats.
        repeat (10) cycle(1, 0, 0, 1);
        drain();

        // Bubble collapse: sparse input against a stalled output.
        for (int k = 0; k < 8; k++) cycle(k % 2 == 0, 0, 0, 1);
        drain();

        // End of frame on the fifth beat, then a single-beat frame from IDLE.
        for (int k = 0; k < 5; k++) cycle(1, k == 4, 1, 1);
        repeat (8) cycle(0, 0, 1, 1);
        cycle(1, 1, 1, 1);
        repeat (8) cycle(0, 0, 1, 1);

        // Simultaneous accept and emit with two beats packed at the tail.
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(1, 0, 1, 1);
        cycle(0, 0, 0, 1);
        drain();

        // Random traffic with varied input/output duty cycles.
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 250; k++) begin
                cycle($urandom_range(0, 99) < piv[s],
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 99) < pord[s], 1);
            end
        end
        drain();

        // Reset while draining a three-beat frame.
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(0, 0, 0, 0);
        repeat (6) cycle(0, 0, 1, 1);

        // Post-reset traffic, then a final drain.
        for (int k = 0; k < 200; k++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, 1);
        end
        drain();
        repeat (2) cycle(0, 0, 1, 1);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_chain_ctrl.md
# delay_chain_ctrl

Elastic valid/ready sequencer for a chain of `DEPTH` enable-gated delay registers in the ORB descriptor datapath. It generates the per-stage `ena` vector that drives the external register chain, and tracks a valid bit and a last bit for each stage. It applies downstream back-pressure without losing data, and drains the chain at end of frame before signalling completion. The data registers themselves live outside this block; it carries control only.

## Interface
- `DEPTH`, 4: number of delay stages controlled, legal range 1..16.
- `CNT_W`, 5: occupancy counter width; must satisfy 2^CNT_W > DEPTH.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk`; `rst`=0 resets).
- `in_valid`  in  1  upstream beat available.
- `in_last`  in  1  qualifies the beat as the last of the frame; sampled only when the beat is accepted.
- `in_ready`  out  1  block accepts a beat this cycle.
- `out_valid`  out  1  last stage holds valid data.
- `out_last`  out  1  last-stage beat is the end of the frame.
- `out_ready`  in  1  downstream takes the beat.
- `stage_ena`  out  DEPTH  enable for delay register i (bit 0 is fed from the input).
- `stage_vld`  out  DEPTH  valid flag of each stage, registered.
- `occupancy`  out  CNT_W  number of valid stages.
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame leaves.

## Operation
- Stage flags: `vld[i]` and `lst[i]` are registers. `out_valid`=`vld[DEPTH-1]` and `out_last`=`lst[DEPTH-1]`.
- Take chain (combinational):
  - `take[DEPTH-1]` = `vld[DEPTH-1]` & `out_ready`.
  - `take[i]` = `vld[i]` & `stage_ena[i+1]`.
- Enables (this collapses bubbles):
  - `stage_ena[i]` = `src_vld[i]` & (~`vld[i]` | `take[i]`).
  - `src_vld[0]` = `in_valid` & `in_ready`.
  - `src_vld[i]` = `vld[i-1]` for i > 0.
- Stage update:
  - On `stage_ena[i]`, `vld[i]`<=1 and `lst[i]`<=source last.
  - Else if `take[i]`, `vld[i]`<=0.
  - Else the stage holds.
- `in_ready` = (state is IDLE or RUN) & (~`vld[0]` | `take[0]`).
- Accept = `in_valid` & `in_ready`. Emit = `out_valid` & `out_ready`.
- `occupancy`:
  - +1 on accept only; -1 on emit only; unchanged when both occur or neither occurs.
  - It never exceeds DEPTH and never underflows.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: an accept with `in_last`=0 goes to RUN; an accept with `in_last`=1 goes to DRAIN.
  - RUN: an accept with `in_last`=1 goes to DRAIN.
  - DRAIN: `in_ready` is forced to 0. An emit with `out_last`=1 goes to DONE.
  - DONE: `frame_done`=1 and `in_ready`=0 for one cycle, then IDLE.
- `busy` = state is not IDLE.
- `in_last` beats only steer the FSM. Data ordering is strictly FIFO.
- With DEPTH=1 the same equations apply: `take[0]` uses `out_ready` directly.

## Timing
- Reset values:
  - `vld`=0, `lst`=0, `stage_ena`=0, `out_valid`=0, `out_last`=0.
  - `occupancy`=0, `busy`=0, `frame_done`=0, state=IDLE.
  - `in_ready`=0 while `rst`=0, and 1 in the first cycle after release.
- Reset asserted mid-frame discards all stage flags on the next edge. No `frame_done` is issued for the aborted frame.
- Latency: a beat accepted at cycle t is presented at `out_valid` at cycle t+DEPTH when there are no stalls.
- Throughput: one beat per cycle while `out_ready`=1.
- Back-pressure: when `out_ready`=0, stages fill from the tail. `in_ready` falls only when `vld[0]`=1 and stage 0 cannot shift.
- `out_valid` remains asserted and the data is held (`stage_ena[DEPTH-1]`=0) until `out_ready`.
- `in_ready` depends combinationally on `out_ready`, through a DEPTH-long path. There is no combinational path from `in_valid` to `in_ready`.
- Full chain plus `out_ready`=1 and an accept in the same cycle: all stages shift and `occupancy` is unchanged.
- Earliest next-frame accept after the last beat is emitted: two cycles later (DONE, then IDLE).

## Test plan
- Reset/streaming (DEPTH=4):
  - Stimulus: release `rst`, then drive `in_valid`=1 and `out_ready`=1 for 10 beats.
  - Required: first `out_valid` 4 cycles after the first accept; 10 contiguous outputs; `occupancy` steady at 4.
- Back-pressure:
  - Stimulus: fill the chain, then hold `out_ready`=0 for 6 cycles.
  - Required: `in_ready`=0 once `occupancy`=4; `stage_ena`=0000; no beat lost or duplicated after `out_ready` returns.
- Bubble collapse:
  - Stimulus: `in_valid` alternating 1/0, `out_ready`=0 for 8 cycles.
  - Required: the valid beats pack into stages 3..0 with no gaps; `occupancy`=4.
- End of frame:
  - Stimulus: 5 beats, the 5th with `in_last`=1.
  - Required: `in_ready`=0 from the cycle after that accept; `out_last` on the 5th output; `frame_done` pulses exactly one cycle later; state returns to IDLE.
- Simultaneous events:
  - Stimulus: at `occupancy`=2, accept and emit in the same cycle.
  - Required: `occupancy` stays at 2.
  - Stimulus: a single beat with `in_last`=1 from IDLE.
  - Required: state goes IDLE to DRAIN to DONE to IDLE.
- Reset mid-operation:
  - Stimulus: assert `rst`=0 in DRAIN with `occupancy`=3.
  - Required: next cycle all outputs are at reset values; no `frame_done`.
